// File: rtl/fifo_wr_arb_if.sv
// Requester/FIFO-write bundle for fifo_wr_arb. The master side holds the requesters and the
// FIFO push port; the slave side is the arbiter.
interface fifo_wr_arb_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NREQ  = 4
);
    localparam int unsigned OW = $clog2(NREQ);

    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       gnt;
    logic                  fifo_wr_en;
    logic [WIDTH-1:0]      fifo_wr_data;
    logic                  fifo_wr_full;
    logic [OW-1:0]         owner;
    logic                  busy;

    modport master (
        output req, req_data, fifo_wr_full,
        input  gnt, fifo_wr_en, fifo_wr_data, owner, busy
    );

    modport slave (
        input  req, req_data, fifo_wr_full,
        output gnt, fifo_wr_en, fifo_wr_data, owner, busy
    );
endinterface

// File: rtl/fifo_wr_arb.sv
// Round-robin burst arbiter: grants one of NREQ requesters the FIFO write port for up to BURST
// beats, handing over without an idle cycle when another requester is waiting.
module fifo_wr_arb #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NREQ  = 4,
    parameter int unsigned BURST = 4
) (
    input logic          wrclk,
    input logic          wr_rst_n,
    fifo_wr_arb_if.slave bus
);
    localparam int unsigned OW = $clog2(NREQ);
    localparam int unsigned CW = $clog2(BURST) + 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BURST - 1);

    typedef enum logic {StIdle, StOwn} state_e;

    state_e          state;
    logic [NREQ-1:0] gnt_q;
    logic [OW-1:0]   owner_q;
    logic [OW-1:0]   last_owner_q;
    logic [CW-1:0]   beat_cnt;
    logic            busy_q;

    logic            accept;
    logic            any_req;
    logic            release_own;
    logic            do_grant;
    logic            go_idle;
    logic [OW-1:0]   pick;
    logic [OW-1:0]   cand;
    logic            pick_found;
    int unsigned     idx;

    // Search from last_owner+1 upward with wrap; last_owner itself is tried last.
    always_comb begin
        pick       = last_owner_q;
        pick_found = 1'b0;
        cand       = '0;
        idx        = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx  = (32'(last_owner_q) + k) % NREQ;
            cand = OW'(idx);
            if (!pick_found && bus.req[cand]) begin
                pick       = cand;
                pick_found = 1'b1;
            end
        end
    end

    always_comb begin
        any_req     = |bus.req;
        accept      = (|(gnt_q & bus.req)) & ~bus.fifo_wr_full;
        release_own = (accept && (beat_cnt == LAST_BEAT)) || !bus.req[owner_q];
        do_grant    = (state == StIdle) ? any_req : (release_own && any_req);
        go_idle     = (state == StOwn) && release_own && !any_req;
    end

    always_ff @(posedge wrclk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            state        <= StIdle;
            gnt_q        <= '0;
            owner_q      <= '0;
            last_owner_q <= OW'(NREQ - 1);
            beat_cnt     <= '0;
            busy_q       <= 1'b0;
        end else if (do_grant) begin
            state        <= StOwn;
            gnt_q        <= NREQ'(1) << pick;
            owner_q      <= pick;
            last_owner_q <= pick;
            beat_cnt     <= '0;
            busy_q       <= 1'b1;
        end else if (go_idle) begin
            state    <= StIdle;
            gnt_q    <= '0;
            beat_cnt <= '0;
            busy_q   <= 1'b0;
        end else if (accept) begin
            beat_cnt <= beat_cnt + 1'b1;
        end
    end

    // Write path is combinational so a beat lands in the same cycle it is accepted.
    assign bus.fifo_wr_en   = accept;
    assign bus.fifo_wr_data = accept ? bus.req_data[owner_q*WIDTH +: WIDTH] : '0;
    assign bus.gnt          = gnt_q;
    assign bus.owner        = owner_q;
    assign bus.busy         = busy_q;
endmodule

// File: tb/tb_fifo_wr_arb.sv
// Bench for fifo_wr_arb: a BURST=4/NREQ=4 instance and a BURST=1/NREQ=3 instance, checked by
// a vector table, directed sequences and a random run against a beats-left reference model.
module tb_fifo_wr_arb;
    localparam int W  = 32;
    localparam int N  = 4;
    localparam int B  = 4;
    localparam int W1 = 8;
    localparam int N1 = 3;
    localparam int B1 = 1;

    logic wrclk    = 1'b0;
    logic wr_rst_n = 1'b0;
    int   checks   = 0;
    int   errors   = 0;

    always #5 wrclk = ~wrclk;

    fifo_wr_arb_if #(.WIDTH(W),  .NREQ(N))  bus  ();
    fifo_wr_arb_if #(.WIDTH(W1), .NREQ(N1)) bus1 ();

    fifo_wr_arb #(.WIDTH(W), .NREQ(N), .BURST(B)) dut (
        .wrclk    (wrclk),
        .wr_rst_n (wr_rst_n),
        .bus      (bus)
    );

    fifo_wr_arb #(.WIDTH(W1), .NREQ(N1), .BURST(B1)) dut1 (
        .wrclk    (wrclk),
        .wr_rst_n (wr_rst_n),
        .bus      (bus1)
    );

    // Reference: a grant holder with a count of beats it may still write.
    typedef struct {
        bit own;
        int owner;
        int last;
        int left;
    } ms_t;

    ms_t m0;
    ms_t m1;
    logic [W-1:0]  exp0[$];
    logic [W-1:0]  act0[$];
    logic [W1-1:0] exp1[$];
    logic [W1-1:0] act1[$];

    function automatic ms_t m_reset(int nreq);
        ms_t m;
        m.own   = 1'b0;
        m.owner = 0;
        m.last  = nreq - 1;
        m.left  = 0;
        return m;
    endfunction

    function automatic int rr_pick(logic [7:0] r, int last, int nreq);
        for (int k = 1; k <= nreq; k++) begin
            int c;
            c = (last + k) % nreq;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    function automatic ms_t m_step(ms_t m, logic [7:0] r, logic full, int nreq, int burst);
        ms_t n;
        bit  free;
        int  p;
        n    = m;
        free = 1'b0;
        if (!m.own) free = 1'b1;
        else if (!r[m.owner]) free = 1'b1;
        else if (!full) begin
            n.left = m.left - 1;
            free   = (n.left == 0);
        end
        if (free) begin
            p = rr_pick(r, m.last, nreq);
            if (p >= 0) begin
                n.own   = 1'b1;
                n.owner = p;
                n.last  = p;
                n.left  = burst;
            end else begin
                n.own = 1'b0;
            end
        end
        return n;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_dut0();
        logic [N-1:0] eg;
        logic         ee;
        logic [W-1:0] ed;
        eg = m0.own ? (N'(1) << m0.owner) : '0;
        ee = m0.own && bus.req[m0.owner] && !bus.fifo_wr_full;
        ed = ee ? bus.req_data[m0.owner*W +: W] : '0;
        chk("d0_gnt", 64'(bus.gnt), 64'(eg));
        chk("d0_wr_en", 64'(bus.fifo_wr_en), 64'(ee));
        chk("d0_wr_data", 64'(bus.fifo_wr_data), 64'(ed));
        chk("d0_busy", 64'(bus.busy), 64'(m0.own));
        chk("d0_wr_while_full", 64'(bus.fifo_wr_en & bus.fifo_wr_full), 64'(0));
        if (m0.own) chk("d0_owner", 64'(bus.owner), 64'(m0.owner));
        if (bus.fifo_wr_en) act0.push_back(bus.fifo_wr_data);
        if (ee) exp0.push_back(ed);
    endtask

    task automatic check_dut1();
        logic [N1-1:0] eg;
        logic          ee;
        logic [W1-1:0] ed;
        eg = m1.own ? (N1'(1) << m1.owner) : '0;
        ee = m1.own && bus1.req[m1.owner] && !bus1.fifo_wr_full;
        ed = ee ? bus1.req_data[m1.owner*W1 +: W1] : '0;
        chk("d1_gnt", 64'(bus1.gnt), 64'(eg));
        chk("d1_wr_en", 64'(bus1.fifo_wr_en), 64'(ee));
        chk("d1_wr_data", 64'(bus1.fifo_wr_data), 64'(ed));
        chk("d1_busy", 64'(bus1.busy), 64'(m1.own));
        chk("d1_wr_while_full", 64'(bus1.fifo_wr_en & bus1.fifo_wr_full), 64'(0));
        if (m1.own) chk("d1_owner", 64'(bus1.owner), 64'(m1.owner));
        if (bus1.fifo_wr_en) act1.push_back(bus1.fifo_wr_data);
        if (ee) exp1.push_back(ed);
    endtask

    task automatic apply(input logic [N-1:0] r0, input logic [N*W-1:0] d0, input logic f0,
                         input logic [N1-1:0] r1, input logic [N1*W1-1:0] d1, input logic f1);
        bus.req           = r0;
        bus.req_data      = d0;
        bus.fifo_wr_full  = f0;
        bus1.req          = r1;
        bus1.req_data     = d1;
        bus1.fifo_wr_full = f1;
    endtask

    task automatic step_a(input logic [N-1:0] r0, input logic [N*W-1:0] d0, input logic f0,
                          input logic [N1-1:0] r1, input logic [N1*W1-1:0] d1, input logic f1);
        apply(r0, d0, f0, r1, d1, f1);
        @(negedge wrclk);
        check_dut0();
        check_dut1();
    endtask

    task automatic step_b();
        @(posedge wrclk);
        m0 = m_step(m0, 8'(bus.req), bus.fifo_wr_full, N, B);
        m1 = m_step(m1, 8'(bus1.req), bus1.fifo_wr_full, N1, B1);
        #1;
    endtask

    task automatic do_reset();
        apply('0, '0, 1'b0, '0, '0, 1'b0);
        wr_rst_n = 1'b0;
        repeat (2) @(posedge wrclk);
        @(negedge wrclk);
        wr_rst_n = 1'b1;
        m0 = m_reset(N);
        m1 = m_reset(N1);
        step_b();
    endtask

    typedef struct {
        logic [N-1:0] req;
        logic         full;
        logic [N-1:0] gnt;
        logic         en;
        logic [W-1:0] data;
    } vec_t;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t           tbl[15];
        logic [N*W-1:0] tdata;
        logic [N*W-1:0] d0;
        logic [N1*W1-1:0] d1;
        logic [N-1:0]   r0;
        logic [N1-1:0]  r1;
        logic           f0;
        logic           f1;

        tbl[0]  = '{4'b0001, 1'b0, 4'b0000, 1'b0, 32'h0};
        tbl[1]  = '{4'b0001, 1'b0, 4'b0001, 1'b1, 32'hC0DE_0000};
        tbl[2]  = '{4'b0011, 1'b1, 4'b0001, 1'b0, 32'h0};
        tbl[3]  = '{4'b0011, 1'b0, 4'b0001, 1'b1, 32'hC0DE_0000};
        tbl[4]  = '{4'b0010, 1'b1, 4'b0001, 1'b0, 32'h0};
        tbl[5]  = '{4'b0110, 1'b0, 4'b0010, 1'b1, 32'hC0DE_0001};
        tbl[6]  = '{4'b0100, 1'b0, 4'b0010, 1'b0, 32'h0};
        tbl[7]  = '{4'b0000, 1'b0, 4'b0100, 1'b0, 32'h0};
        tbl[8]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 32'h0};
        tbl[9]  = '{4'b1001, 1'b0, 4'b0000, 1'b0, 32'h0};
        tbl[10] = '{4'b1001, 1'b0, 4'b1000, 1'b1, 32'hC0DE_0003};
        tbl[11] = '{4'b1001, 1'b0, 4'b1000, 1'b1, 32'hC0DE_0003};
        tbl[12] = '{4'b1001, 1'b0, 4'b1000, 1'b1, 32'hC0DE_0003};
        tbl[13] = '{4'b1001, 1'b0, 4'b1000, 1'b1, 32'hC0DE_0003};
        tbl[14] = '{4'b1001, 1'b0, 4'b0001, 1'b1, 32'hC0DE_0000};
        for (int i = 0; i < N; i++) tdata[i*W +: W] = 32'hC0DE_0000 + 32'(i);

        // Outputs stay zero while reset is held, whatever the requesters do.
        m0 = m_reset(N);
        m1 = m_reset(N1);
        apply('1, tdata, 1'b0, '1, '1, 1'b0);
        #12;
        chk("rst_gnt", 64'(bus.gnt), 64'(0));
        chk("rst_wr_en", 64'(bus.fifo_wr_en), 64'(0));
        chk("rst_wr_data", 64'(bus.fifo_wr_data), 64'(0));
        chk("rst_busy", 64'(bus.busy), 64'(0));
        chk("rst_owner", 64'(bus.owner), 64'(0));
        chk("rst1_wr_en", 64'(bus1.fifo_wr_en), 64'(0));
        do_reset();

        for (int i = 0; i < 15; i++) begin
            step_a(tbl[i].req, tdata, tbl[i].full, '0, '0, 1'b0);
            chk($sformatf("tbl%0d_gnt", i), 64'(bus.gnt), 64'(tbl[i].gnt));
            chk($sformatf("tbl%0d_wr_en", i), 64'(bus.fifo_wr_en), 64'(tbl[i].en));
            chk($sformatf("tbl%0d_wr_data", i), 64'(bus.fifo_wr_data), 64'(tbl[i].data));
            step_b();
        end

        // All four requesting: four-beat bursts rotate 0,1,2,3,0 with no gap.
        do_reset();
        for (int c = 0; c < 18; c++) begin
            step_a(4'b1111, tdata, 1'b0, 3'b111, '1, 1'b0);
            chk($sformatf("rr%0d_gnt", c), 64'(bus.gnt),
                (c == 0) ? 64'(0) : (64'(1) << (((c - 1) / 4) % 4)));
            chk($sformatf("rr%0d_wr_en", c), 64'(bus.fifo_wr_en), (c == 0) ? 64'(0) : 64'(1));
            step_b();
        end

        // Sole requester 2 is re-granted at each burst end without an idle cycle.
        do_reset();
        for (int c = 0; c < 11; c++) begin
            d0 = '0;
            d0[2*W +: W] = 32'(c);
            step_a(4'b0100, d0, 1'b0, '0, '0, 1'b0);
            chk($sformatf("solo%0d_gnt", c), 64'(bus.gnt), (c == 0) ? 64'(0) : 64'(4'b0100));
            chk($sformatf("solo%0d_wr_data", c), 64'(bus.fifo_wr_data), 64'(c));
            step_b();
        end

        // Reset during beat 2 of requester 2 kills the write at once; restart favours 0.
        do_reset();
        step_a(4'b0100, tdata, 1'b0, '0, '0, 1'b0);
        step_b();
        step_a(4'b0100, tdata, 1'b0, '0, '0, 1'b0);
        step_b();
        apply(4'b0100, tdata, 1'b0, '0, '0, 1'b0);
        @(negedge wrclk);
        chk("mid_beat2_wr_en", 64'(bus.fifo_wr_en), 64'(1));
        wr_rst_n = 1'b0;
        #1;
        chk("mid_rst_wr_en", 64'(bus.fifo_wr_en), 64'(0));
        chk("mid_rst_gnt", 64'(bus.gnt), 64'(0));
        chk("mid_rst_wr_data", 64'(bus.fifo_wr_data), 64'(0));
        chk("mid_rst_busy", 64'(bus.busy), 64'(0));
        apply(4'b0101, tdata, 1'b0, '0, '0, 1'b0);
        #1;
        chk("mid_rst_req_wr_en", 64'(bus.fifo_wr_en), 64'(0));
        repeat (2) @(posedge wrclk);
        @(negedge wrclk);
        wr_rst_n = 1'b1;
        m0 = m_reset(N);
        m1 = m_reset(N1);
        step_b();
        step_a(4'b0101, tdata, 1'b0, '0, '0, 1'b0);
        chk("mid_restart_gnt", 64'(bus.gnt), 64'(4'b0001));
        step_b();

        // Random traffic with sticky request lines and random FIFO back-pressure.
        do_reset();
        r0 = '0;
        r1 = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) if ($urandom_range(3) == 0) r0[i] = ~r0[i];
            for (int i = 0; i < N1; i++) if ($urandom_range(3) == 0) r1[i] = ~r1[i];
            for (int i = 0; i < N; i++) d0[i*W +: W] = $urandom;
            for (int i = 0; i < N1; i++) d1[i*W1 +: W1] = W1'($urandom);
            f0 = ($urandom_range(4) == 0);
            f1 = ($urandom_range(4) == 0);
            step_a(r0, d0, f0, r1, d1, f1);
            step_b();
        end

        chk("sb0_len", 64'(act0.size()), 64'(exp0.size()));
        for (int i = 0; i < act0.size() && i < exp0.size(); i++)
            chk($sformatf("sb0_%0d", i), 64'(act0[i]), 64'(exp0[i]));
        chk("sb1_len", 64'(act1.size()), 64'(exp1.size()));
        for (int i = 0; i < act1.size() && i < exp1.size(); i++)
            chk($sformatf("sb1_%0d", i), 64'(act1[i]), 64'(exp1[i]));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 Parameter WIDTH, default 32: data width of each requester and of the FIFO write port.
REQ-002 Parameter NREQ, default 4: number of requesters, legal range 2..8.
REQ-003 Parameter BURST, default 4: maximum accepted beats per grant, legal range 1..16.
REQ-004 wrclk  input  1: single clock, the FIFO write clock; all state on rising edge.
REQ-005 wr_rst_n  input  1: reset, asynchronous, active-low; one clock; all state cleared on assertion.
REQ-006 req  input  NREQ: per-requester beat-valid; req[i] high means req_data slice i holds a valid beat.
REQ-007 req_data  input  NREQ*WIDTH: packed requester data; slice i = bits [i*WIDTH +: WIDTH].
REQ-008 gnt  output  NREQ: registered one-hot-or-zero grant; a beat from i is accepted when gnt[i] & req[i] & !fifo_wr_full.
REQ-009 fifo_wr_en  output  1: write strobe to the FIFO push port.
REQ-010 fifo_wr_data  output  WIDTH: write data to the FIFO.
REQ-011 fifo_wr_full  input  1: FIFO full flag, same clock domain.
REQ-012 owner  output  clog2(NREQ): index of current grant holder, valid when busy=1.
REQ-013 busy  output  1: high while state is OWN.

Function
REQ-014 FSM has two states, IDLE and OWN; gnt is all-zero in IDLE and has exactly one bit set in OWN.
REQ-015 accept = |(gnt & req) & !fifo_wr_full; fifo_wr_en = accept, combinational, same cycle.
REQ-016 fifo_wr_data = req_data slice of owner when accept=1, else all-zero.
REQ-017 fifo_wr_en is never high when fifo_wr_full=1; no beat is dropped or duplicated.
REQ-018 Round-robin pick: search starts at last_owner+1 modulo NREQ and wraps; last_owner has lowest priority and is re-granted only if it is the sole requester.
REQ-019 IDLE -> OWN at the edge after any req bit is high; gnt, owner and last_owner update at that edge; beat_cnt cleared.
REQ-020 IDLE with req all-zero stays IDLE.
REQ-021 In OWN, beat_cnt (width clog2(BURST)+1) increments on each accept; it is held while fifo_wr_full=1.
REQ-022 Release condition in OWN: (accept and beat_cnt == BURST-1) or (req[owner]=0).
REQ-023 On release, if any req bit is high in that cycle, grant hands over at the same edge to the round-robin pick (no idle cycle), beat_cnt cleared; otherwise go to IDLE.
REQ-024 Handover pick on release uses the current owner as last_owner.
REQ-025 Owner deasserting req while fifo_wr_full=1 releases the grant; no beat is written for it.
REQ-026 Requesters other than owner are ignored and see gnt low; their data is never written.
REQ-027 BURST=1: every accepted beat releases; back-to-back beats from different requesters are allowed on consecutive cycles.
REQ-028 Non-owner req changes during a burst do not affect the burst.

Reset
REQ-029 On wr_rst_n low: state IDLE, gnt=0, busy=0, owner=0, beat_cnt=0, last_owner=NREQ-1 (first grant goes to requester 0 if it requests).
REQ-030 fifo_wr_en=0 and fifo_wr_data=0 during reset, independent of req.
REQ-031 Reset assertion mid-burst aborts the burst immediately; no further beats are written; after release, arbitration restarts from requester 0.

Verification
REQ-032 req=4'b1111 held, full=0, BURST=4 -> gnt sequence 0001 (4 beats), 0010 (4), 0100 (4), 1000 (4), 0001; 16 consecutive fifo_wr_en cycles after the first grant edge.
REQ-033 Only req[2] high for 10 beats, BURST=4 -> grant to 2 is re-issued at each release with no idle cycle; 10 writes, data in order.
REQ-034 Owner 0 granted, fifo_wr_full=1 for 5 cycles mid-burst -> fifo_wr_en=0 for those 5 cycles, beat_cnt frozen, burst resumes and ends after 4 total beats.
REQ-035 Owner 1 drops req after 2 beats while req[3] high -> gnt moves 0010 -> 1000 at the next edge; exactly 2 beats from 1 written.
REQ-036 wr_rst_n pulsed low during beat 2 of a burst from requester 2 -> outputs zero immediately; after release with req=4'b0101, first gnt=0001.
REQ-037 Scoreboard across all scenarios: FIFO write sequence equals per-requester accepted beats in grant order; no write with fifo_wr_full=1.
